// File: rtl/ysyx_22050243_mem_pkg.sv
// Shared types and widths for the IFU/LSU data-memory arbiter.
// Optional round-robin arbitration is selected with YSYX_22050243_ARB_RR_EN.
package ysyx_22050243_mem_pkg;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;
   localparam int INST_W = DATA_W / 2;
   localparam int MASK_W = DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_e;

endpackage

// File: rtl/ysyx_22050243_mem_arb_grant.sv
// Combinational grant between IFU and LSU requests.
// YSYX_22050243_ARB_RR_EN: round-robin on ties; otherwise the LSU always wins.
module ysyx_22050243_mem_arb_grant
   import ysyx_22050243_mem_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_ifu_valid,
   input  logic i_lsu_valid,
   input  logic i_done,
   input  logic i_done_owner,
   output logic o_grant_ifu,
   output logic o_grant_lsu
);

`ifdef YSYX_22050243_ARB_RR_EN
   owner_e r_last_owner;

   // Reset value makes the very first tie go to the IFU.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_owner <= OWN_LSU;
      end else if (i_done) begin
         r_last_owner <= owner_e'(i_done_owner);
      end
   end

   assign o_grant_lsu = i_lsu_valid && (!i_ifu_valid || (r_last_owner == OWN_IFU));
`else
   logic w_unused;
   assign w_unused    = ^{clk, rst, i_done, i_done_owner};
   assign o_grant_lsu = i_lsu_valid;
`endif

   assign o_grant_ifu = i_ifu_valid && !o_grant_lsu;

endmodule

// File: rtl/ysyx_22050243_mem_arb.sv
// Shares the single data-memory port between IFU fetches and LSU loads/stores,
// one transaction per IDLE->ACCESS->RESP pass. Tie policy via YSYX_22050243_ARB_RR_EN.
module ysyx_22050243_mem_arb
   import ysyx_22050243_mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   input  logic              ifu_resp_ready,
   output logic [INST_W-1:0] ifu_rdata,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic              lsu_we,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [MASK_W-1:0] lsu_wmask,
   output logic              lsu_resp_valid,
   input  logic              lsu_resp_ready,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              mem_r_en,
   output logic              mem_w_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [MASK_W-1:0] mem_wmask,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_e              r_state;
   state_e              w_next;
   owner_e              r_owner;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [MASK_W-1:0]   r_wmask;
   logic [DATA_W-1:0]   r_rdata;

   logic w_idle;
   logic w_grant_ifu;
   logic w_grant_lsu;
   logic w_fire_ifu;
   logic w_fire_lsu;
   logic w_done;

   // Readies are forced low while reset is held, even though the state is IDLE.
   assign w_idle        = (r_state == ST_IDLE) && !rst;
   assign ifu_req_ready = w_idle && w_grant_ifu;
   assign lsu_req_ready = w_idle && w_grant_lsu;
   assign w_fire_ifu    = ifu_req_valid && ifu_req_ready;
   assign w_fire_lsu    = lsu_req_valid && lsu_req_ready;
   assign w_done        = (r_state == ST_RESP) &&
                          ((r_owner == OWN_IFU) ? ifu_resp_ready : lsu_resp_ready);

   ysyx_22050243_mem_arb_grant u_grant (
      .clk          (clk),
      .rst          (rst),
      .i_ifu_valid  (ifu_req_valid),
      .i_lsu_valid  (lsu_req_valid),
      .i_done       (w_done),
      .i_done_owner (r_owner),
      .o_grant_ifu  (w_grant_ifu),
      .o_grant_lsu  (w_grant_lsu)
   );

   always_comb begin
      w_next         = r_state;
      mem_r_en       = 1'b0;
      mem_w_en       = 1'b0;
      mem_wmask      = '0;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_fire_ifu || w_fire_lsu) w_next = ST_ACCESS;
         end
         ST_ACCESS: begin
            mem_r_en  = !r_we;
            mem_w_en  = r_we;
            mem_wmask = r_we ? r_wmask : '0;
            w_next    = ST_RESP;
         end
         ST_RESP: begin
            ifu_resp_valid = (r_owner == OWN_IFU);
            lsu_resp_valid = (r_owner == OWN_LSU);
            if (w_done) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_owner <= OWN_IFU;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wmask <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         if (w_fire_lsu) begin
            r_owner <= OWN_LSU;
            r_we    <= lsu_we;
            r_addr  <= lsu_addr;
            r_wdata <= lsu_wdata;
            r_wmask <= lsu_wmask;
         end else if (w_fire_ifu) begin
            r_owner <= OWN_IFU;
            r_we    <= 1'b0;
            r_addr  <= ifu_addr;
            r_wmask <= '0;
         end
         // Stores acknowledge with zero data.
         if (r_state == ST_ACCESS) r_rdata <= r_we ? '0 : mem_rdata;
      end
   end

   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign ifu_rdata = r_addr[2] ? r_rdata[DATA_W-1:INST_W] : r_rdata[INST_W-1:0];
   assign lsu_rdata = r_rdata;

endmodule

// File: tb/tb_ysyx_22050243_mem_arb.sv
// Directed bench for ysyx_22050243_mem_arb with a small byte-masked memory model.
// Tie expectations follow YSYX_22050243_ARB_RR_EN when it is defined.
module tb_ysyx_22050243_mem_arb;

`ifdef YSYX_22050243_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
   logic [63:0] ifu_addr;
   logic [31:0] ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_resp_valid, lsu_resp_ready;
   logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [7:0]  lsu_wmask;
   logic        mem_r_en, mem_w_en;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wmask;

   logic        mem_init;
   logic [63:0] mem [0:1023];
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          tb_last_lsu;

   always #5 clk = ~clk;

   ysyx_22050243_mem_arb dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
      .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
   );

   // Memory model: combinational read, byte-masked write at the clock edge.
   assign mem_rdata = mem[mem_addr[12:3]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 64'h0;
         mem[0]      <= 64'h1234_5678_0000_0013;
         mem[1]      <= 64'hA5A5_A5A5_5A5A_5A5A;
         mem[10'h200] <= 64'h1111_2222_3333_4444;
      end else if (mem_w_en) begin
         for (int b = 0; b < 8; b++)
            if (mem_wmask[b]) mem[mem_addr[12:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Called just after a falling edge with the DUT in IDLE; returns just after a
   // falling edge with the DUT back in IDLE.
   task automatic run_txn(input bit lsu, input bit we, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] wmask,
                          input logic [63:0] exp_rd, input int stall);
      if (lsu) begin
         lsu_req_valid = 1'b1; lsu_we = we; lsu_addr = addr;
         lsu_wdata = wdata; lsu_wmask = wmask;
      end else begin
         ifu_req_valid = 1'b1; ifu_addr = addr;
      end
      #1 check(lsu ? "lsu_req_ready" : "ifu_req_ready", lsu ? lsu_req_ready : ifu_req_ready, 1);
      @(negedge clk);
      if (lsu) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
      #1;
      check("acc_r_en", mem_r_en, !we);
      check("acc_w_en", mem_w_en, we);
      check("acc_addr", mem_addr, addr);
      check("acc_wmask", mem_wmask, we ? wmask : 8'h0);
      if (we) check("acc_wdata", mem_wdata, wdata);
      check("acc_no_resp", ifu_resp_valid | lsu_resp_valid, 0);
      for (int i = 0; i <= stall; i++) begin
         @(negedge clk); #1;
         check("resp_valid", lsu ? lsu_resp_valid : ifu_resp_valid, 1);
         check("resp_other", lsu ? ifu_resp_valid : lsu_resp_valid, 0);
         check("resp_rdata", lsu ? lsu_rdata : {32'h0, ifu_rdata}, exp_rd);
         check("resp_no_en", mem_r_en | mem_w_en, 0);
         check("resp_no_grant", ifu_req_ready | lsu_req_ready, 0);
      end
      if (lsu) lsu_resp_ready = 1'b1; else ifu_resp_ready = 1'b1;
      @(negedge clk);
      lsu_resp_ready = 1'b0; ifu_resp_ready = 1'b0;
      #1 check("resp_done", ifu_resp_valid | lsu_resp_valid, 0);
      tb_last_lsu = lsu;
   endtask

   task automatic tie(input logic [63:0] ia, input logic [63:0] ie,
                      input logic [63:0] la, input logic [63:0] le);
      bit lsu_wins;
      lsu_wins = RR ? !tb_last_lsu : 1'b1;
      ifu_req_valid = 1'b1; ifu_addr = ia;
      lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_addr = la;
      #1;
      check("tie_lsu_ready", lsu_req_ready, lsu_wins);
      check("tie_ifu_ready", ifu_req_ready, !lsu_wins);
      if (lsu_wins) begin
         run_txn(1, 0, la, 64'h0, 8'h0, le, 0);
         run_txn(0, 0, ia, 64'h0, 8'h0, ie, 0);
      end else begin
         run_txn(0, 0, ia, 64'h0, 8'h0, ie, 0);
         run_txn(1, 0, la, 64'h0, 8'h0, le, 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; mem_init = 1'b1; tb_last_lsu = 1'b1;
      ifu_req_valid = 1'b1; ifu_addr = 64'h0; ifu_resp_ready = 1'b0;
      lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h0;
      lsu_wdata = 64'h0; lsu_wmask = 8'h0; lsu_resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_ifu_ready", ifu_req_ready, 0);
      check("rst_lsu_ready", lsu_req_ready, 0);
      check("rst_resp", ifu_resp_valid | lsu_resp_valid, 0);
      check("rst_en", mem_r_en | mem_w_en, 0);
      check("rst_addr", mem_addr, 64'h0);
      check("rst_wdata", mem_wdata, 64'h0);
      check("rst_wmask", mem_wmask, 8'h0);
      check("rst_lsu_rdata", lsu_rdata, 64'h0);
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0; mem_init = 1'b0;
      #1 check("idle_no_ready", ifu_req_ready | lsu_req_ready, 0);

      run_txn(0, 0, 64'h8000_0004, 64'h0, 8'h0, 64'h1234_5678, 0);
      run_txn(0, 0, 64'h8000_0000, 64'h0, 8'h0, 64'h0000_0013, 0);
      run_txn(1, 1, 64'h8000_1000, 64'hDEAD_BEEF_CAFE_BABE, 8'h0F, 64'h0, 0);
      run_txn(1, 0, 64'h8000_1000, 64'h0, 8'h0, 64'h1111_2222_CAFE_BABE, 0);

      tie(64'h8000_000C, 64'hA5A5_A5A5, 64'h8000_0008, 64'hA5A5_A5A5_5A5A_5A5A);
      run_txn(0, 0, 64'h8000_0008, 64'h0, 8'h0, 64'h5A5A_5A5A, 0);
      tie(64'h8000_0004, 64'h1234_5678, 64'h8000_0000, 64'h1234_5678_0000_0013);

      run_txn(1, 0, 64'h8000_1000, 64'h0, 8'h0, 64'h1111_2222_CAFE_BABE, 5);

      // Reset in the middle of a store's ACCESS cycle.
      lsu_req_valid = 1'b1; lsu_we = 1'b1; lsu_addr = 64'h8000_1008;
      lsu_wdata = 64'hFFFF_FFFF_FFFF_FFFF; lsu_wmask = 8'hFF;
      #1 check("rs_ready", lsu_req_ready, 1);
      @(negedge clk);
      lsu_req_valid = 1'b0;
      #1 check("rs_w_en", mem_w_en, 1);
      #1 rst = 1'b1;
      #1;
      check("rs_w_en_off", mem_w_en | mem_r_en, 0);
      check("rs_addr", mem_addr, 64'h0);
      check("rs_wdata", mem_wdata, 64'h0);
      check("rs_wmask", mem_wmask, 8'h0);
      check("rs_resp", lsu_resp_valid | ifu_resp_valid, 0);
      @(negedge clk);
      rst = 1'b0; tb_last_lsu = 1'b1;
      #1;
      check("rs_no_commit", mem[10'h201], 64'h0);
      check("rs_idle_resp", lsu_resp_valid | ifu_resp_valid, 0);
      @(negedge clk);
      #1 check("rs_still_idle", lsu_resp_valid | mem_w_en, 0);

      run_txn(0, 0, 64'h8000_0004, 64'h0, 8'h0, 64'h1234_5678, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_22050243_mem_arb.md
Name: ysyx_22050243_mem_arb

Overview:
Arbiter and sequencer sharing the single data-memory port (DPI-backed pmem read/write block) between the instruction fetch unit (IFU) and the load/store unit (LSU). Each requester uses a valid/ready request channel and a valid/ready response channel. The block grants one transaction at a time and drives the memory enables for exactly one cycle per transaction. It registers the read data and returns it to the owning requester.

Parameters:
ADDR_W, 64, address width on all ports
DATA_W, 64, memory data width; LSU data width
INST_W, 32, IFU instruction width (DATA_W/2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
ifu_req_valid  in  1  IFU fetch request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_W  fetch address
ifu_resp_valid  out  1  instruction available
ifu_resp_ready  in  1  IFU accepts response
ifu_rdata  out  INST_W  fetched instruction
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted
lsu_we  in  1  1=store, 0=load
lsu_addr  in  ADDR_W  load/store address
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  DATA_W/8  store byte mask
lsu_resp_valid  out  1  load data / store ack available
lsu_resp_ready  in  1  LSU accepts response
lsu_rdata  out  DATA_W  load data (0 for stores)
mem_r_en  out  1  memory read enable
mem_w_en  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wmask  out  DATA_W/8  memory write mask
mem_rdata  in  DATA_W  memory read data (combinational from mem_addr)

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Owner register: OWN_IFU / OWN_LSU.
- Reset (async, any state): state=IDLE, all req_ready/resp_valid=0, mem_r_en=mem_w_en=0, mem_addr/mem_wdata/mem_wmask/rdata registers=0, owner=OWN_IFU. In-flight transactions are dropped with no response. A write is committed only if its ACCESS clock edge completed before reset.
- IDLE: grant computed combinationally from the valids. The granted requester's req_ready=1; the other's is 0. With no valid, both readies are 0.
- IDLE, on fire (valid&&ready): latch addr, we (IFU we=0), wdata, wmask and owner; go to ACCESS.
- ACCESS (exactly 1 cycle): mem_addr = latched addr; mem_r_en = !we; mem_w_en = we; mem_wmask = latched mask, or 0 when !we.
  - Loads: mem_rdata is captured into the rdata register at the closing edge.
  - Stores: commit at the closing edge; rdata is set to 0.
  - Next state is RESP.
- RESP: owner's resp_valid=1; both req_ready=0. When resp_ready=1, go to IDLE the next cycle. RESP holds indefinitely while resp_ready=0. rdata stays stable while valid.
- Enables are 0 outside ACCESS. mem_addr/mem_wdata hold their last latched values.
- Latency: request fire in cycle N, memory access in N+1, resp_valid from N+2. Back-to-back throughput is one transaction per 3 cycles; IDLE can re-grant in the cycle after the response handshake.
- ifu_rdata = ifu_addr_latched[2] ? rdata[63:32] : rdata[31:0]. Address bits [1:0] are ignored for alignment; no misalignment trap.
- lsu_rdata = full rdata. Byte extraction and sign extension are the LSU's job.
- Default arbitration: fixed priority, LSU over IFU. Simultaneous valids in IDLE grant the LSU.
- Requester valid dropping without fire: no effect. Valid held after fire: treated as a new request at the next IDLE.

Optional Feature:
YSYX_22050243_ARB_RR_EN
- Defined: round-robin arbitration. On simultaneous valids, grant the requester that did not own the most recently completed transaction; a 1-bit last_owner register resets to OWN_LSU, so the first tie grants the IFU.
- Undefined: fixed LSU priority as above, and no last_owner register is built.

Decomposition:
- Shared package ysyx_22050243_mem_pkg: state encoding (IDLE/ACCESS/RESP), owner encoding (OWN_IFU/OWN_LSU), width constants ADDR_W/DATA_W/INST_W.
- One sub-module, ysyx_22050243_mem_arb_grant: combinational grant logic, including the last_owner register under the macro.
- FSM, request latches, rdata register and response muxing stay in the top.

Test Plan:
- IFU fetch, mem[0x80000004]=0x1234567800000013, ifu_addr=0x80000004 -> ifu_resp_valid 2 cycles after fire, ifu_rdata=0x12345678; mem_r_en high exactly 1 cycle.
- LSU store addr=0x80001000, wdata=0xDEADBEEFCAFEBABE, wmask=0x0F, then LSU load same addr -> lsu_rdata low 32 bits=0xCAFEBABE, upper bytes unchanged; store resp lsu_rdata=0.
- Both valid in the same IDLE cycle -> default build: LSU granted first, IFU served next. With RR_EN: first tie grants IFU, next tie grants LSU.
- resp_ready held low 5 cycles in RESP -> resp_valid and rdata stable, no mem enables, no new grant; completes the cycle after resp_ready rises.
- rst asserted during ACCESS of a store -> all outputs zero asynchronously, no response issued, FSM restarts in IDLE; a subsequent fetch completes normally.
